// File: rtl/hazard_scoreboard.sv
// RAW hazard detection and forwarding-select generation for the ID stage.
// A shift-register scoreboard tracks in-flight writers behind ID; each ID
// source is matched against it to pick a forwarding stage or raise a stall.
module hazard_scoreboard #(
    parameter int unsigned REG_ADDR_W     = 4,
    parameter int unsigned PIPE_DEPTH     = 3,
    parameter int unsigned FWD_EN         = 1,
    parameter int unsigned RF_WRITE_FIRST = 1,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               id_valid,
    input  logic                               id_wb_en,
    input  logic                               id_mem_r_en,
    input  logic [REG_ADDR_W-1:0]              id_dest,
    input  logic [REG_ADDR_W-1:0]              id_src1,
    input  logic                               id_src1_used,
    input  logic [REG_ADDR_W-1:0]              id_src2,
    input  logic                               id_src2_used,
    input  logic                               flush,
    input  logic                               stat_clr,
    output logic                               stall,
    output logic [$clog2(PIPE_DEPTH+1)-1:0]    fwd_sel1,
    output logic [$clog2(PIPE_DEPTH+1)-1:0]    fwd_sel2,
    output logic [CNT_W-1:0]                   stall_count
);

    localparam int unsigned SW  = $clog2(PIPE_DEPTH + 1);
    // With write-first register file the WB entry is already visible to ID.
    localparam int unsigned WIN = (RF_WRITE_FIRST != 0) ? PIPE_DEPTH - 1 : PIPE_DEPTH;

    logic                  ent_v    [1:PIPE_DEPTH];
    logic                  ent_wb   [1:PIPE_DEPTH];
    logic                  ent_ld   [1:PIPE_DEPTH];
    logic [REG_ADDR_W-1:0] ent_dest [1:PIPE_DEPTH];

    logic          hit1, hit2;
    logic          ld1, ld2;
    logic [SW-1:0] k1, k2;
    logic          haz1, haz2;

    // Youngest matching writer inside the hazard window, per source.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        ld1  = 1'b0;
        ld2  = 1'b0;
        k1   = '0;
        k2   = '0;
        for (int unsigned k = 1; k <= WIN; k++) begin
            if (!hit1 && ent_v[k] && ent_wb[k] && id_src1_used && (ent_dest[k] == id_src1)) begin
                hit1 = 1'b1;
                k1   = SW'(k);
                ld1  = ent_ld[k];
            end
            if (!hit2 && ent_v[k] && ent_wb[k] && id_src2_used && (ent_dest[k] == id_src2)) begin
                hit2 = 1'b1;
                k2   = SW'(k);
                ld2  = ent_ld[k];
            end
        end
    end

    // Hazard classification, stall and forwarding select.
    always_comb begin
        if (FWD_EN != 0) begin
            haz1 = hit1 && (k1 == SW'(1)) && ld1;
            haz2 = hit2 && (k2 == SW'(1)) && ld2;
        end else begin
            haz1 = hit1;
            haz2 = hit2;
        end
        stall    = id_valid && !flush && (haz1 || haz2);
        fwd_sel1 = '0;
        fwd_sel2 = '0;
        if ((FWD_EN != 0) && !stall) begin
            fwd_sel1 = hit1 ? k1 : '0;
            fwd_sel2 = hit2 ? k2 : '0;
        end
    end

    // Scoreboard shift; a bubble enters when ID is stalled, flushed or empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 1; k <= PIPE_DEPTH; k++) begin
                ent_v[k]    <= 1'b0;
                ent_wb[k]   <= 1'b0;
                ent_ld[k]   <= 1'b0;
                ent_dest[k] <= '0;
            end
        end else begin
            for (int unsigned k = 2; k <= PIPE_DEPTH; k++) begin
                ent_v[k]    <= ent_v[k-1];
                ent_wb[k]   <= ent_wb[k-1];
                ent_ld[k]   <= ent_ld[k-1];
                ent_dest[k] <= ent_dest[k-1];
            end
            ent_v[1]    <= id_valid && !stall && !flush;
            ent_wb[1]   <= id_wb_en;
            ent_ld[1]   <= id_mem_r_en;
            ent_dest[1] <= id_dest;
        end
    end

    // Saturating stall-cycle counter; clear has priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
        end else if (stat_clr) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule
